// File: rtl/axis_uart_pkg.sv
// Shared definitions for the UART receive-side frame decoder.
// Holds the decoder state encoding and the default HDLC-style byte values.
package axis_uart_pkg;

    typedef enum logic [1:0] {
        HUNT,
        OPEN,
        ESCD,
        DISCARD
    } deframer_state_t;

    localparam logic [7:0] FLAG_BYTE = 8'h7E;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

endpackage

// File: rtl/axis_uart_deframer_if.sv
// Byte-wide AXI4-Stream bundle used on both sides of the frame decoder.
// The input side leaves tlast/tuser unused.
interface axis_uart_deframer_if;

    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);

endinterface

// File: rtl/axis_uart_deframer.sv
// HDLC-style frame decoder: strips flags and escapes from the rxbyte stream
// and emits payload packets with tlast on the final byte, tuser on errors.
// Optional statistics counters are enabled with AXIS_UART_DEFRAMER_STATS_EN.
module axis_uart_deframer #(
    parameter logic [7:0] FLAG_BYTE = axis_uart_pkg::FLAG_BYTE,
    parameter logic [7:0] ESC_BYTE  = axis_uart_pkg::ESC_BYTE,
    parameter logic [7:0] ESC_XOR   = axis_uart_pkg::ESC_XOR,
    parameter int         MAX_LEN   = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_uart_deframer_if.slave   rxbyte,
    axis_uart_deframer_if.master  frame
`ifdef AXIS_UART_DEFRAMER_STATS_EN
    ,
    output logic [15:0]           frame_count,
    output logic [15:0]           error_count
`endif
);

    import axis_uart_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    deframer_state_t  state;
    logic             hold_valid;
    logic [7:0]       hold_data;
    logic [LEN_W-1:0] len;

    logic             accept;
    logic             is_flag;
    logic             is_esc;
    logic             do_push;
    logic [7:0]       push_byte;

    logic             unused_rx;
    assign unused_rx = ^{rxbyte.tlast, rxbyte.tuser};

    // Accept input only when the single output register is free or draining.
    assign rxbyte.tready = aresetn && (!frame.tvalid || frame.tready);

    // Classify the incoming byte and decide whether it becomes payload.
    always_comb begin
        accept    = rxbyte.tvalid && rxbyte.tready;
        is_flag   = (rxbyte.tdata == FLAG_BYTE);
        is_esc    = (rxbyte.tdata == ESC_BYTE);
        do_push   = 1'b0;
        push_byte = rxbyte.tdata;
        if (accept) begin
            if (state == OPEN && !is_flag && !is_esc) begin
                do_push = 1'b1;
            end else if (state == ESCD && !is_flag) begin
                do_push   = 1'b1;
                push_byte = rxbyte.tdata ^ ESC_XOR;
            end
        end
    end

    // Decoder FSM, hold register, length counter and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= HUNT;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            len          <= '0;
            frame.tvalid <= 1'b0;
            frame.tdata  <= '0;
            frame.tlast  <= 1'b0;
            frame.tuser  <= 1'b0;
        end else begin
            if (frame.tvalid && frame.tready) begin
                frame.tvalid <= 1'b0;
            end

            if (do_push) begin
                if (len == LEN_MAX) begin
                    // Overlong: the held byte closes the frame as an error.
                    frame.tvalid <= 1'b1;
                    frame.tdata  <= hold_data;
                    frame.tlast  <= 1'b1;
                    frame.tuser  <= 1'b1;
                    hold_valid   <= 1'b0;
                    state        <= DISCARD;
                end else begin
                    if (hold_valid) begin
                        frame.tvalid <= 1'b1;
                        frame.tdata  <= hold_data;
                        frame.tlast  <= 1'b0;
                        frame.tuser  <= 1'b0;
                    end
                    hold_data  <= push_byte;
                    hold_valid <= 1'b1;
                    len        <= len + LEN_W'(1);
                    state      <= OPEN;
                end
            end else if (accept) begin
                case (state)
                    HUNT: begin
                        if (is_flag) begin
                            state <= OPEN;
                        end
                    end
                    OPEN: begin
                        if (is_flag) begin
                            if (hold_valid) begin
                                frame.tvalid <= 1'b1;
                                frame.tdata  <= hold_data;
                                frame.tlast  <= 1'b1;
                                frame.tuser  <= 1'b0;
                            end
                            hold_valid <= 1'b0;
                            len        <= '0;
                        end else if (is_esc) begin
                            state <= ESCD;
                        end
                    end
                    ESCD: begin
                        // Only a flag reaches here: escape-then-flag aborts.
                        if (hold_valid) begin
                            frame.tvalid <= 1'b1;
                            frame.tdata  <= hold_data;
                            frame.tlast  <= 1'b1;
                            frame.tuser  <= 1'b1;
                        end
                        hold_valid <= 1'b0;
                        len        <= '0;
                        state      <= OPEN;
                    end
                    DISCARD: begin
                        if (is_flag) begin
                            len   <= '0;
                            state <= OPEN;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef AXIS_UART_DEFRAMER_STATS_EN
    // Saturating good/bad frame counters, stepped on the tlast handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            error_count <= '0;
        end else if (frame.tvalid && frame.tready && frame.tlast) begin
            if (frame.tuser) begin
                if (error_count != '1) begin
                    error_count <= error_count + 16'd1;
                end
            end else begin
                if (frame_count != '1) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule
